adder_result_stage: RTL
=======================

Name: adder_result_stage

Overview:
- Downstream stage of the 64-bit fast adder. Captures the combinational adder outputs (sum, carry) together with operand sign information.
- Derives status flags and presents results to the consumer through a 2-entry skid FIFO with a valid/ready handshake.
- Breaks the long carry-chain timing path and decouples the adder from back-pressure.

Parameters:
- W, 64, datapath width; must match the adder's W.
- CW, 16, width of the accepted-result counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  adder result valid this cycle.
- in_ready  output  1  stage can accept; registered, equals (count<2).
- in_sum  input  W  adder sum output.
- in_carry  input  1  adder carry output.
- in_op  input  1  operation bit used by the adder (1 = subtract).
- in_a_msb  input  1  a[W-1] as fed to the adder.
- in_b_msb  input  1  MSB of the effective b operand (after negation when in_op=1).
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- out_sum  output  W  head sum.
- out_carry  output  1  head carry.
- out_op  output  1  head operation bit.
- out_zero  output  1  head sum == 0.
- out_neg  output  1  head sum[W-1].
- out_ovf  output  1  signed overflow of head result.
- result_count  output  CW  number of results accepted since reset.

Behaviour:
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- Flags are computed at push time from the inputs and stored with the entry:
  - zero = (in_sum == 0)
  - neg = in_sum[W-1]
  - ovf = (in_a_msb == in_b_msb) && (in_sum[W-1] != in_a_msb)
- Carry is stored raw, with no borrow inversion.
- Storage is 2 entries (head, tail) with an occupancy count of 0..2. Outputs come directly from the head registers, with no combinational path from in_* to out_*.
- Latency: an entry pushed in cycle N appears on out_* with out_valid=1 in cycle N+1 when the FIFO was empty.
- in_ready is registered (count<2 after the update). Consequences:
  - in_ready is never combinationally dependent on out_ready.
  - At count=2, a pop in cycle N raises in_ready in cycle N+1.
- Count update rules:
  - Push and no pop: count+1.
  - Pop and no push: count-1; tail moves to head.
  - Push and pop at count=1: head is replaced by the new entry; count stays 1.
  - Push and pop at count=2: cannot occur, since in_ready=0.
- in_valid while in_ready=0 is ignored. Upstream holds its data; this stage does not track it.
- out_* hold their values while out_valid=1 and out_ready=0 (stable under back-pressure).
- When count=0, out_valid=0 and out_* data fields hold their last value.
- result_count increments by 1 on each push and wraps modulo 2^CW.
- Reset (asynchronous, any cycle, including mid-transfer):
  - Values: count=0, in_ready=1, out_valid=0, out_sum=0, out_carry=0, out_op=0, out_zero=0, out_neg=0, out_ovf=0, result_count=0.
  - All stored entries are discarded.
  - The first push is possible in the first clock edge after rst deasserts.

Test Plan:
- Reset with in_valid=1 held -> all outputs 0, in_ready=1 during rst. First edge after release pushes; out_valid=1 the next cycle.
- Push sum=0x7FFF_FFFF_FFFF_FFFF, a_msb=0, b_msb=0, carry=0 -> out_neg=1? No: out_neg=0, out_ovf=0, out_zero=0. Then push sum=0x8000_0000_0000_0000, a_msb=0, b_msb=0 -> out_neg=1, out_ovf=1.
- Subtract 5-5: sum=0, carry=1, op=1, a_msb=0, b_msb=1 -> out_zero=1, out_carry=1, out_op=1, out_ovf=0.
- Hold out_ready=0, present 3 consecutive valid results A, B, C:
  - A and B accepted; in_ready=0 from the cycle after B; C is held upstream.
  - out_* stay equal to A.
  - Raise out_ready -> order A, B, C delivered; result_count ends at 3.
- out_ready=1 with in_valid=1 streaming 100 results -> one result out per cycle after 1-cycle latency, in_ready stays 1, order preserved, result_count=100.
- Assert rst for one cycle with count=2 -> out_valid=0, result_count=0, in_ready=1 immediately. Stale entries never appear on out_*.

Source files
------------

// File: rtl/adder_result_stage.sv
// adder_result_stage
//   Registers the combinational outputs of the 64-bit fast adder, derives
//   zero/negative/signed-overflow flags at capture time and hands the results
//   to a consumer through a 2-entry skid FIFO with a valid/ready handshake.
//   Cuts the adder carry-chain timing path and isolates it from back-pressure.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is registered)
//   in_sum, in_carry    adder result
//   in_op               adder operation (1 = subtract)
//   in_a_msb, in_b_msb  operand sign bits as seen by the adder
//   out_valid/out_ready downstream handshake
//   out_sum .. out_ovf  FIFO head payload and flags
//   result_count        number of accepted results, wraps modulo 2^CW
module adder_result_stage #(
  parameter int unsigned W  = 64,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_sum,
  input  logic          in_carry,
  input  logic          in_op,
  input  logic          in_a_msb,
  input  logic          in_b_msb,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sum,
  output logic          out_carry,
  output logic          out_op,
  output logic          out_zero,
  output logic          out_neg,
  output logic          out_ovf,
  output logic [CW-1:0] result_count
);

  localparam int unsigned CNT_W = 2;

  // One stored result with its flags
  typedef struct packed {
    logic [W-1:0] sum;
    logic         carry;
    logic         op;
    logic         zero;
    logic         neg;
    logic         ovf;
  } entry_t;

  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [CW-1:0]    result_count_q, result_count_d;

  logic   push;
  logic   pop;
  entry_t new_entry;

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  // Flags are evaluated on the incoming result and stored with it
  always_comb begin
    new_entry       = '0;
    new_entry.sum   = in_sum;
    new_entry.carry = in_carry;
    new_entry.op    = in_op;
    new_entry.zero  = (in_sum == '0);
    new_entry.neg   = in_sum[W-1];
    new_entry.ovf   = (in_a_msb == in_b_msb) && (in_sum[W-1] != in_a_msb);
  end

  // FIFO next-state: head feeds the outputs directly, tail is the skid slot
  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    result_count_d = result_count_q;

    if (push) begin
      result_count_d = result_count_q + CW'(1);
    end

    unique case ({push, pop})
      2'b10: begin
        if (count_q == CNT_W'(0)) begin
          head_d = new_entry;
        end else begin
          tail_d = new_entry;
        end
        count_d = count_q + CNT_W'(1);
      end
      2'b01: begin
        // Leaving the head untouched when draining the last entry keeps the
        // data outputs at their last value while empty.
        if (count_q == CNT_W'(2)) begin
          head_d = tail_q;
        end
        count_d = count_q - CNT_W'(1);
      end
      2'b11: begin
        // Only reachable at count 1 since in_ready is low when full
        head_d = new_entry;
      end
      default: begin
      end
    endcase

    out_valid_d = (count_d != CNT_W'(0));
    in_ready_d  = (count_d < CNT_W'(2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      out_valid_q    <= 1'b0;
      in_ready_q     <= 1'b1;
      result_count_q <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      out_valid_q    <= out_valid_d;
      in_ready_q     <= in_ready_d;
      result_count_q <= result_count_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_sum      = head_q.sum;
  assign out_carry    = head_q.carry;
  assign out_op       = head_q.op;
  assign out_zero     = head_q.zero;
  assign out_neg      = head_q.neg;
  assign out_ovf      = head_q.ovf;
  assign result_count = result_count_q;

endmodule
